// File: rtl/l2_bus_arbiter.sv
// Round-robin arbiter that places two L1 cache controllers onto one shared L2 request
// port, pulsing a snoop-invalidate to the other core on every granted write.
module l2_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_stall,
  output logic              c0_done,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_stall,
  output logic              c1_done,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              l2_req,
  output logic              l2_we,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic              l2_ack,
  input  logic [DATA_W-1:0] l2_rdata,
  output logic              snoop_inv,
  output logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_core,
  output logic              err,
  output logic [1:0]        dbg_state
);
  // Handshake: cN_req is held until cN_done pulses; l2_req is held until l2_ack,
  // and l2_ack is honoured only while l2_req is high.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] c0_rdata_q, c0_rdata_d;
  logic [DATA_W-1:0] c1_rdata_q, c1_rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              winner;
  logic [DATA_W-1:0] resp_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      c0_rdata_q   <= '0;
      c1_rdata_q   <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      c0_rdata_q   <= c0_rdata_d;
      c1_rdata_q   <= c1_rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    c0_rdata_d   = c0_rdata_q;
    c1_rdata_d   = c1_rdata_q;
    cnt_d        = cnt_q;
    resp_data    = '0;
    // Core1 wins alone, or on a tie when core0 held the previous grant.
    winner       = c1_req & ~(c0_req & last_grant_q);
    case (state_q)
      IDLE: begin
        if (c0_req || c1_req) begin
          owner_d      = winner;
          last_grant_d = winner;
          we_d         = winner ? c1_we : c0_we;
          addr_d       = winner ? c1_addr : c0_addr;
          wdata_d      = winner ? c1_wdata : c0_wdata;
          cnt_d        = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (l2_ack) begin
          resp_data = we_q ? '0 : l2_rdata;
          state_d   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (state_d == RESP) begin
          if (owner_q) c1_rdata_d = resp_data;
          else         c0_rdata_d = resp_data;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign l2_req     = (state_q == ISSUE);
  assign l2_we      = we_q;
  assign l2_addr    = addr_q;
  assign l2_wdata   = wdata_q;
  assign snoop_inv  = (state_q == ISSUE) && (cnt_q == '0) && we_q;
  assign snoop_addr = addr_q;
  assign snoop_core = snoop_inv & ~owner_q;
  assign c0_done    = (state_q == RESP) && !owner_q;
  assign c1_done    = (state_q == RESP) && owner_q;
  assign c0_rdata   = c0_rdata_q;
  assign c1_rdata   = c1_rdata_q;
  assign c0_stall   = c0_req & ~c0_done;
  assign c1_stall   = c1_req & ~c1_done;
  assign err        = err_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Bench for l2_bus_arbiter: directed transactions, expected done responses queued
// at issue and checked by an independent monitor.
module tb_l2_bus_arbiter;
  localparam int TMO   = 8;
  localparam int EXP_W = 34;

  logic        clk, reset;
  logic        c0_req, c0_we, c0_stall, c0_done;
  logic [31:0] c0_addr, c0_wdata, c0_rdata;
  logic        c1_req, c1_we, c1_stall, c1_done;
  logic [31:0] c1_addr, c1_wdata, c1_rdata;
  logic        l2_req, l2_we, l2_ack;
  logic [31:0] l2_addr, l2_wdata, l2_rdata;
  logic        snoop_inv, snoop_core, err;
  logic [31:0] snoop_addr;
  logic [1:0]  dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  logic [31:0]      hold_rd[2];
  int n_checks = 0;
  int n_fail   = 0;

  l2_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_stall(c0_stall), .c0_done(c0_done), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_stall(c1_stall), .c1_done(c1_done), .c1_rdata(c1_rdata),
    .l2_req(l2_req), .l2_we(l2_we), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_ack(l2_ack), .l2_rdata(l2_rdata),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr), .snoop_core(snoop_core),
    .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit core, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (core) begin
      c1_req = req; c1_we = we; c1_addr = addr; c1_wdata = wdata;
    end else begin
      c0_req = req; c0_we = we; c0_addr = addr; c0_wdata = wdata;
    end
  endtask

  task automatic push_exp(input bit core, input logic [31:0] rd, input bit e);
    exp_q.push_back({e, core, rd});
    hold_rd[core] = rd;
  endtask

  // Single-core transaction; ack_delay >= TMO means L2 never answers.
  task automatic core_txn(input bit core, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_delay,
                          input logic [31:0] rd, input bit exp_err);
    bit acked;
    acked = (ack_delay < TMO);
    set_req(core, 1'b1, we, addr, wdata);
    @(negedge clk);
    check("idle_stall", core ? c1_stall : c0_stall, 1);
    tick();
    for (int i = 0; i < TMO; i++) begin
      if (i == ack_delay) begin
        l2_ack = 1'b1;
        l2_rdata = rd;
      end
      @(negedge clk);
      check("issue_l2_req", l2_req, 1);
      check("issue_stall", core ? c1_stall : c0_stall, 1);
      check("issue_snoop_inv", snoop_inv, (i == 0) && we);
      if (!acked) check("issue_err_low", err, 0);
      if (i == 0) begin
        check("l2_we", l2_we, we);
        check("l2_addr", l2_addr, addr);
        if (we) begin
          check("l2_wdata", l2_wdata, wdata);
          check("snoop_addr", snoop_addr, addr);
          check("snoop_core", snoop_core, !core);
        end
      end
      if (i == ack_delay) break;
      if (i < TMO - 1) tick();
    end
    push_exp(core, (we || !acked) ? 32'h0 : rd, exp_err);
    tick();
    l2_ack = 1'b0;
    @(negedge clk);
    check("resp_l2_req", l2_req, 0);
    check("resp_stall", core ? c1_stall : c0_stall, 0);
    tick();
    set_req(core, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Both cores request continuously; grants must alternate starting at first.
  task automatic both_grants(input bit first, input int n);
    bit cur;
    set_req(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h2000, 32'h0);
    for (int g = 0; g < n; g++) begin
      cur = first ^ g[0];
      @(negedge clk);
      check("gap_idle", dbg_state, 2'd0);
      tick();
      @(negedge clk);
      check("grant_l2_req", l2_req, 1);
      check("grant_addr", l2_addr, cur ? 32'h2000 : 32'h1000);
      check("loser_stall_issue", cur ? c0_stall : c1_stall, 1);
      check("grant_snoop_inv", snoop_inv, 0);
      l2_ack = 1'b1;
      l2_rdata = 32'hA000_0000 + 32'(g);
      push_exp(cur, 32'hA000_0000 + 32'(g), 1'b0);
      tick();
      l2_ack = 1'b0;
      @(negedge clk);
      check("resp_state", dbg_state, 2'd2);
      check("loser_stall_resp", cur ? c0_stall : c1_stall, 1);
      tick();
    end
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (c0_done || c1_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got c0_done=%0b c1_done=%0b expected none at %0t",
                 c0_done, c1_done, $time);
      end else begin
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        check("done_onehot", c0_done & c1_done, 0);
        check("done_core", c1_done, e[32]);
        check("done_rdata", e[32] ? c1_rdata : c0_rdata, e[31:0]);
        check("done_err", err, e[33]);
      end
    end
  end

  initial begin
    reset = 1'b0;
    l2_ack = 1'b0;
    l2_rdata = 32'h0;
    hold_rd[0] = 32'h0;
    hold_rd[1] = 32'h0;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", dbg_state, 2'd0);
    check("rst_l2_req", l2_req, 0);
    check("rst_l2_addr", l2_addr, 0);
    check("rst_snoop", {snoop_inv, snoop_core}, 0);
    check("rst_done", {c0_done, c1_done}, 0);
    check("rst_rdata", {c0_rdata, c1_rdata}, 0);
    check("rst_err", err, 0);
    tick();
    reset = 1'b1;
    tick();

    // round-robin from reset: core0, core1, core0
    both_grants(1'b0, 3);
    // core0 read, ack two cycles after l2_req rises
    core_txn(1'b0, 1'b0, 32'h40, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);
    // core1 write triggers a snoop to core0
    core_txn(1'b1, 1'b1, 32'h100, 32'h1234_5678, 1, 32'h0, 1'b0);
    @(negedge clk);
    check("c0_rdata_hold", c0_rdata, hold_rd[0]);
    check("c1_rdata_hold", c1_rdata, hold_rd[1]);
    tick();
    // L2 never acks: timeout, then a normal transaction with err still set
    core_txn(1'b0, 1'b0, 32'h200, 32'h0, TMO, 32'h0, 1'b1);
    core_txn(1'b1, 1'b0, 32'h204, 32'h0, 0, 32'h55AA_55AA, 1'b1);
    @(negedge clk);
    check("err_sticky", err, 1);
    tick();

    // reset in the middle of a core0 write
    set_req(1'b0, 1'b1, 1'b1, 32'h300, 32'hCAFE_F00D);
    tick();
    @(negedge clk);
    check("pre_rst_snoop", snoop_inv, 1);
    check("pre_rst_l2_req", l2_req, 1);
    #1 reset = 1'b0;
    #1;
    check("async_l2_req", l2_req, 0);
    check("async_snoop", snoop_inv, 0);
    check("async_done", {c0_done, c1_done}, 0);
    check("async_state", dbg_state, 2'd0);
    check("async_err", err, 0);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    hold_rd[0] = 32'h0;
    hold_rd[1] = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    both_grants(1'b0, 2);

    // stray ack while idle
    l2_ack = 1'b1;
    l2_rdata = 32'hFFFF_FFFF;
    tick();
    l2_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_ack_state", dbg_state, 2'd0);
      check("stray_ack_l2_req", l2_req, 0);
      tick();
    end
    check("final_c0_rdata", c0_rdata, hold_rd[0]);
    check("final_c1_rdata", c1_rdata, hold_rd[1]);
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/l2_bus_arbiter.md
Name: l2_bus_arbiter

Overview:
- Sequences access from the two cores' L1 cache controllers (core 0, core 1) onto the single shared L2 request port.
- Grants one L1 miss or write-through at a time using round-robin priority, and stalls the losing core.
- On each granted write, pulses a snoop-invalidate to the other core's L1 to keep the two L1 caches coherent.
- Sits between the two L1 controllers and the L2 cache in the multicore top.

Parameters:
ADDR_W, 32, byte address width of L1/L2 requests
DATA_W, 32, data word width
TIMEOUT, 64, max cycles waiting for l2_ack before an error abort (must be ≥ 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
c0_req  in  1  core0 L1 request; held high until c0_done
c0_we  in  1  core0 write (1) / read (0)
c0_addr  in  ADDR_W  core0 address
c0_wdata  in  DATA_W  core0 write data
c0_stall  out  1  core0 must hold its pipeline
c0_done  out  1  one-cycle completion pulse to core0
c0_rdata  out  DATA_W  read data for core0, valid with c0_done
c1_req, c1_we, c1_addr, c1_wdata, c1_stall, c1_done, c1_rdata: same as core0, for core1
l2_req  out  1  request to L2, held until l2_ack
l2_we  out  1  latched write flag
l2_addr  out  ADDR_W  latched address
l2_wdata  out  DATA_W  latched write data
l2_ack  in  1  L2 completion; sampled only while l2_req=1
l2_rdata  in  DATA_W  L2 read data, valid with l2_ack
snoop_inv  out  1  one-cycle invalidate pulse
snoop_addr  out  ADDR_W  address to invalidate
snoop_core  out  1  target core of the invalidate (the core that was not granted)
err  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state IDLE, last_grant=1 (so core0 wins the first tie), timeout counter 0. A reset during a transaction aborts it immediately; l2_req drops asynchronously and no done pulse is issued.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any cN_req=1, pick the winner. Single requester: that core wins. Both requesting: the core != last_grant wins.
  - Latch the winner's we, addr and wdata; set owner and last_grant to the winner; go to ISSUE.
- ISSUE:
  - l2_req=1, with l2_we/l2_addr/l2_wdata taken from the latched fields. These stay stable for the whole of ISSUE.
  - If l2_ack=1: latch l2_rdata (or zero for a write); go to RESP.
  - Timeout counter counts ISSUE cycles. If it reaches TIMEOUT-1 with no ack: set err=1, latch rdata=0, go to RESP. An ack in that same cycle takes priority and err is not set.
- Snoop:
  - snoop_inv=1 for exactly the first ISSUE cycle of a write.
  - snoop_addr = latched address; snoop_core = !owner.
  - Never asserted for reads.
- RESP:
  - c<owner>_done=1 and c<owner>_rdata = latched data for one cycle.
  - l2_req=0; go to IDLE.
  - cN_rdata holds its value until the next done for that core.
- Stall: cN_stall = cN_req AND NOT (state==RESP AND owner==N). This is combinational from registered state.
- Latency:
  - req sampled in cycle 0, l2_req asserted in cycle 1.
  - ack in cycle k gives done in cycle k+1, with IDLE again in cycle k+2.
  - Minimum is 3 cycles per transaction; back-to-back grants are separated by one IDLE cycle.
- Fairness: under continuous requests from both cores, grants strictly alternate.
- A requester dropping cN_req mid-transaction is a protocol violation. The transaction still completes and done is still pulsed.
- l2_ack outside ISSUE is ignored.
- err stays set until reset. It does not block further transactions.

Test Plan:
1. Core0 only, read of 0x40: L2 acks 2 cycles after l2_req with rdata 0xDEADBEEF → c0_done pulses in the cycle after ack with c0_rdata=0xDEADBEEF; c0_stall=1 every cycle before that; snoop_inv stays 0.
2. Both cores request in the same cycle after reset → core0 granted first, then core1, then core0; c1_stall=1 throughout core0's transaction; exactly one IDLE cycle between grants.
3. Core1 write of 0x100 with wdata=0x12345678 → l2_we=1, l2_addr=0x100, l2_wdata=0x12345678; snoop_inv=1 for one cycle with snoop_addr=0x100 and snoop_core=0.
4. L2 never acks with TIMEOUT=8 → l2_req high for 8 cycles, then err=1 and c0_done with c0_rdata=0; the next request is still served normally and err stays 1.
5. reset driven low while in ISSUE → l2_req, snoop_inv and cN_done go to 0 immediately; after release, a simultaneous request grants core0 first.
6. l2_ack pulsed while in IDLE with no requests → no state change and no done pulses.
